// File: rtl/pipelined_bypass_adder.sv
// pipelined_bypass_adder
//   Pipelined carry-bypass adder/subtractor. The operands are split into
//   STAGES segments of SEG = WIDTH/STAGES bits. Each pipeline stage adds one
//   segment, LSB segment first, using SEG/BLOCK carry-bypass blocks. The
//   inter-stage carry, the operand bits and the sat flag travel with the
//   transaction. The completed lower sum bits are also carried forward.
//   The final stage derives signed overflow and applies saturation before
//   the output register, so a, b and the flags never reach sum
//   combinationally.
//
// Parameters
//   WIDTH  : operand/result width (divisible by STAGES)
//   STAGES : number of register stages = latency in cycles (>= 1)
//   BLOCK  : carry-bypass block size (divides WIDTH/STAGES)
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   in_valid, in_ready : operand handshake (in_ready = !out_valid | out_ready)
//   a, b, cin, sub, sat: operands, carry-in, subtract mode, saturate enable
//   out_valid, out_ready : result handshake
//   sum, cout, overflow  : result, MSB carry-out, signed overflow
module pipelined_bypass_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int BLOCK  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int NBLK = SEG / BLOCK;

    localparam logic [WIDTH-1:0] SUM_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SUM_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Stage registers. Index STAGES-1 is the output register.
    logic [WIDTH-1:0] a_r     [STAGES];
    logic [WIDTH-1:0] b_r     [STAGES];
    logic [WIDTH-1:0] sum_r   [STAGES];
    logic             carry_r [STAGES];
    logic             sat_r   [STAGES];
    logic             valid_r [STAGES];
    logic             ovf_r;

    // Combinational result of each stage, loaded into the matching register.
    logic [WIDTH-1:0] nx_a_s     [STAGES];
    logic [WIDTH-1:0] nx_b_s     [STAGES];
    logic [WIDTH-1:0] nx_sum_s   [STAGES];
    logic             nx_carry_s [STAGES];
    logic             nx_sat_s   [STAGES];
    logic             nx_valid_s [STAGES];
    logic             nx_ovf_s;
    logic             advance_s;

    // The whole pipeline moves together whenever the output slot can be freed.
    assign advance_s = !valid_r[STAGES-1] || out_ready;
    assign in_ready  = advance_s;
    assign out_valid = valid_r[STAGES-1];
    assign sum       = sum_r[STAGES-1];
    assign cout      = carry_r[STAGES-1];
    assign overflow  = ovf_r;

    // Per-stage segment addition with carry bypass, plus final overflow/saturation.
    always_comb begin
        logic [WIDTH-1:0] op_a;
        logic [WIDTH-1:0] op_b;
        logic [WIDTH-1:0] op_sum;
        logic             op_c;
        logic             op_sat;
        logic             op_valid;
        logic             c;
        logic             p;
        logic             blk_c;
        logic             c_msb;
        int               idx;

        nx_ovf_s = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                // Subtraction is a + ~b + 1: invert b once and force carry-in.
                op_a     = a;
                op_sum   = {WIDTH{1'b0}};
                op_sat   = sat;
                op_valid = in_valid;
                if (sub) begin
                    op_b = ~b;
                    op_c = 1'b1;
                end else begin
                    op_b = b;
                    op_c = cin;
                end
            end else begin
                op_a     = a_r[k-1];
                op_b     = b_r[k-1];
                op_sum   = sum_r[k-1];
                op_c     = carry_r[k-1];
                op_sat   = sat_r[k-1];
                op_valid = valid_r[k-1];
            end

            c     = op_c;
            c_msb = 1'b0;
            for (int j = 0; j < NBLK; j++) begin
                blk_c = c;
                p     = 1'b1;
                for (int i = 0; i < BLOCK; i++) begin
                    idx = k * SEG + j * BLOCK + i;
                    if (idx == WIDTH - 1) begin
                        c_msb = c;
                    end else begin
                        c_msb = c_msb;
                    end
                    op_sum[idx] = op_a[idx] ^ op_b[idx] ^ c;
                    p           = p & (op_a[idx] ^ op_b[idx]);
                    c           = (op_a[idx] & op_b[idx]) | (c & (op_a[idx] ^ op_b[idx]));
                end
                // A fully propagating block passes its carry-in straight through.
                if (p) begin
                    c = blk_c;
                end else begin
                    c = c;
                end
            end

            nx_a_s[k]     = op_a;
            nx_b_s[k]     = op_b;
            nx_sum_s[k]   = op_sum;
            nx_carry_s[k] = c;
            nx_sat_s[k]   = op_sat;
            nx_valid_s[k] = op_valid;

            if (k == STAGES - 1) begin
                nx_ovf_s = c_msb ^ c;
                // On overflow the true result's sign equals the sign of a.
                if (op_sat && nx_ovf_s) begin
                    nx_sum_s[k] = op_a[WIDTH-1] ? SUM_MIN : SUM_MAX;
                end else begin
                    nx_sum_s[k] = op_sum;
                end
            end else begin
                nx_ovf_s = nx_ovf_s;
            end
        end
    end

    // Pipeline registers: reset clears everything, otherwise shift on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]     <= {WIDTH{1'b0}};
                b_r[k]     <= {WIDTH{1'b0}};
                sum_r[k]   <= {WIDTH{1'b0}};
                carry_r[k] <= 1'b0;
                sat_r[k]   <= 1'b0;
                valid_r[k] <= 1'b0;
            end
            ovf_r <= 1'b0;
        end else if (advance_s) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_r[k] <= nx_valid_s[k];
                // Bubbles leave the data untouched so operands load only on accept.
                if (nx_valid_s[k]) begin
                    a_r[k]     <= nx_a_s[k];
                    b_r[k]     <= nx_b_s[k];
                    sum_r[k]   <= nx_sum_s[k];
                    carry_r[k] <= nx_carry_s[k];
                    sat_r[k]   <= nx_sat_s[k];
                end
            end
            if (nx_valid_s[STAGES-1]) begin
                ovf_r <= nx_ovf_s;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_bypass_adder.sv
// Testbench for pipelined_bypass_adder (WIDTH=32, STAGES=2, BLOCK=4).
// Directed table vectors, streaming with backpressure, reset mid-stream and
// a randomized phase checked against an arithmetic reference model.
module tb_pipelined_bypass_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int BLOCK  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    pipelined_bypass_adder #(.WIDTH(WIDTH), .STAGES(STAGES), .BLOCK(BLOCK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic        sat;
        logic [31:0] e_sum;
        logic        e_cout;
        logic        e_ovf;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then range test for overflow.
    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic mcin, input logic msub, input logic msat);
        exp_t   e;
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        longint res;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ua = {32'd0, ma};
        ub = {32'd0, mb};
        if (msub) res = sa - sb;
        else      res = sa + sb + longint'({63'd0, mcin});
        e.ovf = (res > 64'sd2147483647) || (res < -64'sd2147483648);
        if (msub) e.cout = (ua >= ub);
        else      e.cout = ((ua + ub + longint'({63'd0, mcin})) > 64'sd4294967295);
        if (e.ovf && msat) e.sum = (res > 64'sd0) ? 32'h7FFFFFFF : 32'h80000000;
        else               e.sum = res[31:0];
        return e;
    endfunction

    // Scoreboard/monitor: sampled on the falling edge, mid-cycle.
    logic        hold_prev = 1'b0;
    logic [34:0] prev_out;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_stable", {sum, cout, overflow, out_valid}, prev_out);
            end
            if (out_valid && out_ready) begin
                check("output_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("stream_sum",  sum,      e.sum);
                    check("stream_cout", cout,     e.cout);
                    check("stream_ovf",  overflow, e.ovf);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub, sat));
            end
            hold_prev = out_valid && !out_ready;
            prev_out  = {sum, cout, overflow, out_valid};
        end
    end

    task automatic drive(input logic v, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic tc, input logic ts, input logic tsat, input logic ordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        a         = ta;
        b         = tb_;
        cin       = tc;
        sub       = ts;
        sat       = tsat;
        out_ready = ordy;
    endtask

    task automatic drain();
        int w;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t        tbl[10];
    logic [31:0] st_a[8];
    logic [31:0] st_b[8];

    initial begin
        int lat;
        int got;
        int si;
        int seen;

        tbl[0] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1};
        tbl[2] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
        tbl[3] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b1};
        tbl[4] = '{32'd100,      32'd150,      1'b0, 1'b1, 1'b0, 32'hFFFFFFCE, 1'b0, 1'b0};
        tbl[5] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[6] = '{32'd5,        32'd3,        1'b1, 1'b1, 1'b0, 32'd2,        1'b1, 1'b0};
        tbl[7] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b1};
        tbl[8] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[9] = '{32'h12345678, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0, 32'h21436587, 1'b0, 1'b0};

        st_a = '{32'd100, 32'd200, -32'sd100, 32'd50, -32'sd50, 32'h7FFFFFFF, 32'd1000, 32'h55555555};
        st_b = '{-32'sd50, 32'd150, -32'sd200, 32'd75, 32'd50, 32'h7FFFFFFF, -32'sd1000, 32'h2AAAAAAA};

        rst = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0;
        cin = 1'b0; sub = 1'b0; sat = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_sum",       sum,       32'd0);
        check("reset_cout",      cout,      1'b0);
        check("reset_ovf",       overflow,  1'b0);
        check("reset_in_ready",  in_ready,  1'b1);

        // Directed vectors, one at a time; first one also measures latency.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].sat, 1'b1);
            @(posedge clk);
            #1 in_valid = 1'b0;
            lat = 0;
            got = 0;
            while (got == 0 && lat < 20) begin
                @(negedge clk);
                lat++;
                if (out_valid) got = 1;
            end
            check($sformatf("tbl%0d_valid", i), 64'(got), 64'd1);
            if (i == 0) check("latency", 64'(lat), 64'(STAGES));
            check($sformatf("tbl%0d_sum", i),  sum,      tbl[i].e_sum);
            check($sformatf("tbl%0d_cout", i), cout,     tbl[i].e_cout);
            check($sformatf("tbl%0d_ovf", i),  overflow, tbl[i].e_ovf);
        end

        // Back-to-back stream with a 5-cycle stall in the middle.
        si = 0;
        for (int cyc = 0; cyc < 30 && si < 8; cyc++) begin
            logic stall;
            stall = (cyc >= 4) && (cyc < 9);
            drive(1'b1, st_a[si], st_b[si], 1'b0, 1'b0, 1'b0, !stall);
            @(negedge clk);
            if (stall) check("bp_in_ready",     in_ready, 1'b0);
            else       check("stream_in_ready", in_ready, 1'b1);
            if (in_ready) si++;
        end
        check("stream_all_sent", 64'(si), 64'd8);
        drain();

        // Reset with two transactions in flight: both must vanish.
        drive(1'b1, 32'd11, 32'd22, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'd33, 32'd44, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_sum",       sum,       32'd0);
        check("rst_mid_in_ready",  in_ready,  1'b1);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_mid_no_ghost", 64'(seen), 64'd0);

        // Randomized traffic with random backpressure and biased operands.
        for (int k = 0; k < 400; k++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = {ra[31], {31{~ra[31]}}};
            if ($urandom_range(0, 3) == 0) rb = {rb[31], {31{~rb[31]}}};
            drive($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
